// File: rtl/clock_pkg.sv
// Shared types, limits and helpers for the BCD timekeeper.
// Time is held in 24h BCD form everywhere; 12h is a display-only view.
package clock_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t SEC_T_MAX     = 4'd5;
   localparam bcd_t DIG_MAX       = 4'd9;
   localparam bcd_t HR_T_MAX      = 4'd2;
   localparam bcd_t HR_O_MAX_AT_2 = 4'd3;
   localparam int   HR_NOON       = 12;

   typedef struct packed {
      bcd_t hr_t;
      bcd_t hr_o;
      bcd_t min_t;
      bcd_t min_o;
      bcd_t sec_t;
      bcd_t sec_o;
   } clk_time_t;

   function automatic logic time_valid(clk_time_t t);
      logic ok;
      ok = (t.sec_t <= SEC_T_MAX) && (t.sec_o <= DIG_MAX) &&
           (t.min_t <= SEC_T_MAX) && (t.min_o <= DIG_MAX) &&
           (t.hr_t  <= HR_T_MAX)  && (t.hr_o  <= DIG_MAX);
      if (t.hr_t == HR_T_MAX && t.hr_o > HR_O_MAX_AT_2) ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [4:0] bcd2_to_bin(bcd_t tens, bcd_t ones);
      return 5'(tens) * 5'd10 + 5'(ones);
   endfunction

endpackage

// File: rtl/clock_core_param_if.sv
// Control, load, alarm and display bundle of the clock core.
// The DUT takes the slave view; the driver/board side takes the master view.
interface clock_core_param_if;
   import clock_pkg::*;

   logic       run_en;
   logic       mode_12h;
   logic       load;
   bcd_t       load_hr_t, load_hr_o, load_min_t, load_min_o, load_sec_t, load_sec_o;
   logic       alarm_en;
   bcd_t       alarm_hr_t, alarm_hr_o, alarm_min_t, alarm_min_o;

   logic       tick_1hz;
   logic       load_err;
   logic       day_wrap;
   logic       alarm_hit;
   logic       pm;
   bcd_t       sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
   logic [6:0] sec_ones_seg, sec_tens_seg, min_ones_seg, min_tens_seg, hr_ones_seg, hr_tens_seg;

   modport master (
      output run_en, mode_12h, load,
      output load_hr_t, load_hr_o, load_min_t, load_min_o, load_sec_t, load_sec_o,
      output alarm_en, alarm_hr_t, alarm_hr_o, alarm_min_t, alarm_min_o,
      input  tick_1hz, load_err, day_wrap, alarm_hit, pm,
      input  sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens,
      input  sec_ones_seg, sec_tens_seg, min_ones_seg, min_tens_seg, hr_ones_seg, hr_tens_seg
   );

   modport slave (
      input  run_en, mode_12h, load,
      input  load_hr_t, load_hr_o, load_min_t, load_min_o, load_sec_t, load_sec_o,
      input  alarm_en, alarm_hr_t, alarm_hr_o, alarm_min_t, alarm_min_o,
      output tick_1hz, load_err, day_wrap, alarm_hit, pm,
      output sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens,
      output sec_ones_seg, sec_tens_seg, min_ones_seg, min_tens_seg, hr_ones_seg, hr_tens_seg
   );

endinterface

// File: rtl/clock_prescaler.sv
// Clock-enable prescaler: wrap is the combinational terminal-count strobe,
// tick is its registered copy (high the cycle after the terminal count).
module clock_prescaler #(
   parameter int CLK_HZ = 50_000_000,
   parameter int PRE_W  = $clog2(CLK_HZ)
) (
   input  logic clk,
   input  logic reset,
   input  logic run_en,
   input  logic clear,
   output logic wrap,
   output logic tick
);

   localparam logic [PRE_W-1:0] TERM = PRE_W'(CLK_HZ - 1);

   logic [PRE_W-1:0] count;

   assign wrap = run_en && (count == TERM);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= wrap;
         // A load restarts the second so the next tick is a full period away.
         if (clear || wrap) count <= '0;
         else if (run_en)   count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/seven_segment_decoder.sv
// BCD digit to active-high 7-segment pattern, bit order {g,f,e,d,c,b,a}.
// Non-decimal codes blank the digit.
module seven_segment_decoder (
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h00;
      case (digit)
         4'd0: seg = 7'h3F;
         4'd1: seg = 7'h06;
         4'd2: seg = 7'h5B;
         4'd3: seg = 7'h4F;
         4'd4: seg = 7'h66;
         4'd5: seg = 7'h6D;
         4'd6: seg = 7'h7D;
         4'd7: seg = 7'h07;
         4'd8: seg = 7'h7F;
         4'd9: seg = 7'h6F;
         default: seg = 7'h00;
      endcase
   end

endmodule

// File: rtl/clock_core_param.sv
// HH:MM:SS BCD timekeeper with prescaled enable, validated load,
// 12h/24h display view, run/pause and an HH:MM alarm.
module clock_core_param
   import clock_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int PRE_W  = $clog2(CLK_HZ)
) (
   input logic                clk,
   input logic                reset,
   clock_core_param_if.slave  bus
);

   clk_time_t  cur;
   clk_time_t  nxt;
   clk_time_t  load_val;
   logic       load_ok;
   logic       wrap;
   logic       load_err_q, day_wrap_q, alarm_hit_q;
   logic [4:0] hr_bin, hr_12;
   logic       pm_12;
   bcd_t       disp_hr_t, disp_hr_o;
   logic       disp_pm;

   assign load_val = {bus.load_hr_t, bus.load_hr_o, bus.load_min_t,
                      bus.load_min_o, bus.load_sec_t, bus.load_sec_o};
   assign load_ok  = time_valid(load_val);

   clock_prescaler #(.CLK_HZ(CLK_HZ), .PRE_W(PRE_W)) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .run_en (bus.run_en),
      .clear  (bus.load && load_ok),
      .wrap   (wrap),
      .tick   (bus.tick_1hz)
   );

   // One-second BCD increment with ripple carries sec -> min -> hour.
   always_comb begin
      nxt = cur;
      if (cur.sec_o != DIG_MAX) begin
         nxt.sec_o = cur.sec_o + 4'd1;
      end else begin
         nxt.sec_o = '0;
         if (cur.sec_t != SEC_T_MAX) begin
            nxt.sec_t = cur.sec_t + 4'd1;
         end else begin
            nxt.sec_t = '0;
            if (cur.min_o != DIG_MAX) begin
               nxt.min_o = cur.min_o + 4'd1;
            end else begin
               nxt.min_o = '0;
               if (cur.min_t != SEC_T_MAX) begin
                  nxt.min_t = cur.min_t + 4'd1;
               end else begin
                  nxt.min_t = '0;
                  if (cur.hr_t == HR_T_MAX && cur.hr_o == HR_O_MAX_AT_2) begin
                     nxt.hr_t = '0;
                     nxt.hr_o = '0;
                  end else if (cur.hr_o == DIG_MAX) begin
                     nxt.hr_t = cur.hr_t + 4'd1;
                     nxt.hr_o = '0;
                  end else begin
                     nxt.hr_o = cur.hr_o + 4'd1;
                  end
               end
            end
         end
      end
   end

   // A valid load wins over a coincident tick; an invalid load is ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur         <= '0;
         load_err_q  <= 1'b0;
         day_wrap_q  <= 1'b0;
         alarm_hit_q <= 1'b0;
      end else begin
         load_err_q  <= bus.load && !load_ok;
         day_wrap_q  <= 1'b0;
         alarm_hit_q <= 1'b0;
         if (bus.load && load_ok) begin
            cur <= load_val;
         end else if (wrap) begin
            cur         <= nxt;
            day_wrap_q  <= (nxt == '0);
            alarm_hit_q <= bus.alarm_en &&
                           nxt.sec_t == 4'd0 && nxt.sec_o == 4'd0 &&
                           nxt.hr_t  == bus.alarm_hr_t  && nxt.hr_o  == bus.alarm_hr_o &&
                           nxt.min_t == bus.alarm_min_t && nxt.min_o == bus.alarm_min_o;
         end
      end
   end

   assign bus.load_err  = load_err_q;
   assign bus.day_wrap  = day_wrap_q;
   assign bus.alarm_hit = alarm_hit_q;

   // 12h view: 00 -> 12 AM, 12 -> 12 PM, 13..23 -> 01..11 PM.
   always_comb begin
      hr_bin    = bcd2_to_bin(cur.hr_t, cur.hr_o);
      hr_12     = hr_bin;
      pm_12     = 1'b0;
      disp_hr_t = cur.hr_t;
      disp_hr_o = cur.hr_o;
      disp_pm   = 1'b0;
      if (hr_bin == 5'd0) begin
         hr_12 = 5'(HR_NOON);
      end else if (hr_bin >= 5'(HR_NOON)) begin
         pm_12 = 1'b1;
         if (hr_bin != 5'(HR_NOON)) hr_12 = hr_bin - 5'(HR_NOON);
      end
      if (bus.mode_12h) begin
         disp_pm = pm_12;
         if (hr_12 >= 5'd10) begin
            disp_hr_t = 4'd1;
            disp_hr_o = 4'(hr_12 - 5'd10);
         end else begin
            disp_hr_t = 4'd0;
            disp_hr_o = 4'(hr_12);
         end
      end
   end

   assign bus.pm       = disp_pm;
   assign bus.sec_ones = cur.sec_o;
   assign bus.sec_tens = cur.sec_t;
   assign bus.min_ones = cur.min_o;
   assign bus.min_tens = cur.min_t;
   assign bus.hr_ones  = disp_hr_o;
   assign bus.hr_tens  = disp_hr_t;

   seven_segment_decoder u_seg_so (.digit(cur.sec_o), .seg(bus.sec_ones_seg));
   seven_segment_decoder u_seg_st (.digit(cur.sec_t), .seg(bus.sec_tens_seg));
   seven_segment_decoder u_seg_mo (.digit(cur.min_o), .seg(bus.min_ones_seg));
   seven_segment_decoder u_seg_mt (.digit(cur.min_t), .seg(bus.min_tens_seg));
   seven_segment_decoder u_seg_ho (.digit(disp_hr_o), .seg(bus.hr_ones_seg));
   seven_segment_decoder u_seg_ht (.digit(disp_hr_t), .seg(bus.hr_tens_seg));

endmodule

// File: tb/tb_clock_core_param.sv
// Bench for clock_core_param at CLK_HZ=4: a seconds-of-day reference model
// predicts each tick and queues the expected time, popped when tick_1hz fires.
module tb_clock_core_param;

   localparam int CLK_HZ = 4;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   logic [23:0] exp_q[$];
   int          m_time, m_cnt;
   bit          m_tick, m_dwrap, m_alarm, m_lerr;

   clock_core_param_if ifc();

   clock_core_param #(.CLK_HZ(CLK_HZ)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   function automatic logic [23:0] to_bcd24(input int t);
      int h, m, s;
      h = t / 3600; m = (t / 60) % 60; s = t % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [23:0] disp24();
      return {ifc.hr_tens, ifc.hr_ones, ifc.min_tens, ifc.min_ones, ifc.sec_tens, ifc.sec_ones};
   endfunction

   // {pm, tens, ones} of the 12h view of a 24h hour
   function automatic logic [8:0] exp_12h(input int h);
      int dh;
      dh = h % 12;
      if (dh == 0) dh = 12;
      return {(h >= 12) ? 1'b1 : 1'b0, 4'(dh / 10), 4'(dh % 10)};
   endfunction

   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] tab [10];
      tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      return tab[d];
   endfunction

   task automatic model_reset();
      m_time = 0; m_cnt = 0;
      m_tick = 0; m_dwrap = 0; m_alarm = 0; m_lerr = 0;
      exp_q.delete();
   endtask

   // Advance one clock: predict from the inputs applied now, then sample at negedge.
   task automatic tick_cycle();
      bit wrap, valid;
      int lt, al;
      wrap  = ifc.run_en && (m_cnt == CLK_HZ - 1);
      valid = ifc.load_sec_t <= 5 && ifc.load_sec_o <= 9 && ifc.load_min_t <= 5 &&
              ifc.load_min_o <= 9 && ifc.load_hr_o <= 9 &&
              (ifc.load_hr_t < 2 || (ifc.load_hr_t == 2 && ifc.load_hr_o <= 3));
      lt = (ifc.load_hr_t * 10 + ifc.load_hr_o) * 3600 +
           (ifc.load_min_t * 10 + ifc.load_min_o) * 60 +
           ifc.load_sec_t * 10 + ifc.load_sec_o;
      al = (ifc.alarm_hr_t * 10 + ifc.alarm_hr_o) * 60 + ifc.alarm_min_t * 10 + ifc.alarm_min_o;
      m_tick = wrap; m_dwrap = 0; m_alarm = 0;
      m_lerr = ifc.load && !valid;
      if (ifc.load && valid) begin
         m_time = lt;
         m_cnt  = 0;
      end else begin
         if (ifc.run_en) m_cnt = wrap ? 0 : m_cnt + 1;
         if (wrap) begin
            m_time  = (m_time + 1) % 86400;
            m_dwrap = (m_time == 0);
            m_alarm = ifc.alarm_en && (m_time % 60 == 0) && (m_time / 60 == al);
         end
      end
      if (wrap) exp_q.push_back(to_bcd24(m_time));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_load(input int h, input int m, input int s);
      ifc.load = 1'b1;
      ifc.load_hr_t  = 4'(h / 10); ifc.load_hr_o  = 4'(h % 10);
      ifc.load_min_t = 4'(m / 10); ifc.load_min_o = 4'(m % 10);
      ifc.load_sec_t = 4'(s / 10); ifc.load_sec_o = 4'(s % 10);
      tick_cycle();
      ifc.load = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      ifc.mode_12h = 1'b0;
      do_reset();
      checks++;
      if (disp24() !== 24'h000000 || ifc.pm !== 1'b0) begin
         failures++; $display("FAIL reset_24h: got %h pm=%b want 000000 pm=0", disp24(), ifc.pm);
      end
      checks++;
      if ({ifc.tick_1hz, ifc.load_err, ifc.day_wrap, ifc.alarm_hit} !== 4'b0000) begin
         failures++; $display("FAIL reset_pulses: got %b want 0000",
                              {ifc.tick_1hz, ifc.load_err, ifc.day_wrap, ifc.alarm_hit});
      end
      ifc.mode_12h = 1'b1;
      #1;
      checks++;
      if ({ifc.pm, ifc.hr_tens, ifc.hr_ones} !== exp_12h(0) || ifc.hr_tens_seg !== seg_of(1) ||
          ifc.hr_ones_seg !== seg_of(2)) begin
         failures++; $display("FAIL reset_12h: got pm=%b %h%h segs %h %h want %h",
                              ifc.pm, ifc.hr_tens, ifc.hr_ones, ifc.hr_tens_seg, ifc.hr_ones_seg, exp_12h(0));
      end
      ifc.mode_12h = 1'b0;
   endtask

   task automatic test_count();
      logic [23:0] e;
      do_reset();
      ifc.run_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick_cycle();
         checks++;
         if (ifc.tick_1hz !== m_tick) begin
            failures++; $display("FAIL count_tick cyc %0d: got %b want %b", i, ifc.tick_1hz, m_tick);
         end
         if (ifc.tick_1hz === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (disp24() !== e) begin
               failures++; $display("FAIL count_time cyc %0d: got %h want %h", i, disp24(), e);
            end
         end
      end
      checks++;
      if (disp24() !== 24'h000010 || exp_q.size() != 0) begin
         failures++; $display("FAIL count_final: got %h want 000010 (left %0d)", disp24(), exp_q.size());
      end
      checks++;
      if (ifc.sec_tens_seg !== seg_of(1) || ifc.sec_ones_seg !== seg_of(0)) begin
         failures++; $display("FAIL count_segs: got %h %h want %h %h",
                              ifc.sec_tens_seg, ifc.sec_ones_seg, seg_of(1), seg_of(0));
      end
      ifc.run_en = 1'b0;
   endtask

   task automatic test_rollover();
      logic [23:0] e;
      int sh [2] = '{23, 12};
      int sm [2] = '{59, 59};
      do_reset();
      for (int k = 0; k < 2; k++) begin
         ifc.run_en = 1'b0;
         drive_load(sh[k], sm[k], 59);
         ifc.run_en = 1'b1;
         for (int i = 0; i < CLK_HZ; i++) begin
            tick_cycle();
            checks++;
            if (ifc.tick_1hz !== m_tick || ifc.day_wrap !== m_dwrap) begin
               failures++; $display("FAIL rollover_pulse %0d/%0d: got tick=%b wrap=%b want %b %b",
                                    k, i, ifc.tick_1hz, ifc.day_wrap, m_tick, m_dwrap);
            end
            if (ifc.tick_1hz === 1'b1 && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checks++;
               if (disp24() !== e) begin
                  failures++; $display("FAIL rollover_time %0d: got %h want %h", k, disp24(), e);
               end
            end
         end
      end
      ifc.run_en = 1'b0;
      ifc.mode_12h = 1'b1;
      #1;
      checks++;
      if ({ifc.pm, ifc.hr_tens, ifc.hr_ones} !== exp_12h(13) || ifc.hr_ones_seg !== seg_of(1)) begin
         failures++; $display("FAIL rollover_12h: got pm=%b %h%h want %h",
                              ifc.pm, ifc.hr_tens, ifc.hr_ones, exp_12h(13));
      end
      ifc.mode_12h = 1'b0;
   endtask

   task automatic test_mode_12h();
      int hrs [4] = '{20, 12, 11, 0};
      ifc.mode_12h = 1'b1;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive_load(hrs[k], 15, 0);
         checks++;
         if ({ifc.pm, ifc.hr_tens, ifc.hr_ones} !== exp_12h(hrs[k]) ||
             {ifc.min_tens, ifc.min_ones, ifc.sec_tens, ifc.sec_ones} !== 16'h1500) begin
            failures++; $display("FAIL mode12_hr%0d: got pm=%b %h want %h", hrs[k], ifc.pm,
                                 disp24(), exp_12h(hrs[k]));
         end
      end
      drive_load(20, 15, 0);
      ifc.mode_12h = 1'b0;
      #1;
      checks++;
      if (disp24() !== 24'h201500 || ifc.pm !== 1'b0) begin
         failures++; $display("FAIL mode24_back: got %h pm=%b want 201500 pm=0", disp24(), ifc.pm);
      end
   endtask

   task automatic test_load_err();
      int bh [2] = '{24, 10};
      int bm [2] = '{0, 60};
      do_reset();
      drive_load(8, 9, 10);
      for (int k = 0; k < 2; k++) begin
         drive_load(bh[k], bm[k], 0);
         checks++;
         if (ifc.load_err !== m_lerr || ifc.load_err !== 1'b1 || disp24() !== 24'h080910) begin
            failures++; $display("FAIL load_err_%0d: got err=%b time=%h want err=1 time=080910",
                                 k, ifc.load_err, disp24());
         end
         tick_cycle();
         checks++;
         if (ifc.load_err !== 1'b0) begin
            failures++; $display("FAIL load_err_len_%0d: got %b want 0", k, ifc.load_err);
         end
      end
   endtask

   task automatic test_load_vs_tick();
      logic [23:0] e;
      do_reset();
      ifc.run_en = 1'b1;
      repeat (CLK_HZ - 1) tick_cycle();
      drive_load(5, 6, 7);
      checks++;
      if (disp24() !== 24'h050607) begin
         failures++; $display("FAIL load_beats_tick: got %h want 050607", disp24());
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      for (int i = 0; i < CLK_HZ; i++) begin
         tick_cycle();
         checks++;
         if (ifc.tick_1hz !== (i == CLK_HZ - 1)) begin
            failures++; $display("FAIL load_next_tick cyc %0d: got %b", i, ifc.tick_1hz);
         end
         if (ifc.tick_1hz === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (disp24() !== e) begin
               failures++; $display("FAIL load_next_time: got %h want %h", disp24(), e);
            end
         end
      end
      ifc.run_en = 1'b0;
   endtask

   task automatic test_alarm();
      int hits;
      bit en [2] = '{1'b1, 1'b0};
      ifc.alarm_hr_t = 4'd0; ifc.alarm_hr_o = 4'd7;
      ifc.alarm_min_t = 4'd3; ifc.alarm_min_o = 4'd0;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         ifc.alarm_en = en[k];
         ifc.run_en = 1'b0;
         drive_load(7, 29, 59);
         ifc.run_en = 1'b1;
         hits = 0;
         for (int i = 0; i < 2 * CLK_HZ; i++) begin
            tick_cycle();
            hits += int'(ifc.alarm_hit);
            checks++;
            if (ifc.alarm_hit !== m_alarm) begin
               failures++; $display("FAIL alarm_en%0d cyc %0d: got %b want %b", en[k], i, ifc.alarm_hit, m_alarm);
            end
         end
         checks++;
         if (hits != (en[k] ? 1 : 0)) begin
            failures++; $display("FAIL alarm_count_en%0d: got %0d want %0d", en[k], hits, en[k] ? 1 : 0);
         end
         exp_q.delete();
      end
      ifc.alarm_en = 1'b1;
      ifc.run_en = 1'b0;
      drive_load(7, 30, 0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (ifc.alarm_hit !== 1'b0) begin
            failures++; $display("FAIL alarm_on_load cyc %0d: got %b want 0", i, ifc.alarm_hit);
         end
         tick_cycle();
      end
      ifc.alarm_en = 1'b0;
   endtask

   task automatic test_pause();
      logic [23:0] held;
      do_reset();
      ifc.run_en = 1'b1;
      repeat (6) tick_cycle();
      exp_q.delete();
      held = disp24();
      ifc.run_en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick_cycle();
         checks++;
         if (ifc.tick_1hz !== 1'b0 || disp24() !== held) begin
            failures++; $display("FAIL pause cyc %0d: got tick=%b time=%h want 0 %h", i, ifc.tick_1hz, disp24(), held);
         end
      end
      ifc.run_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick_cycle();
         checks++;
         if (ifc.tick_1hz !== m_tick) begin
            failures++; $display("FAIL resume cyc %0d: got %b want %b", i, ifc.tick_1hz, m_tick);
         end
      end
      checks++;
      if (disp24() !== 24'h000002) begin
         failures++; $display("FAIL resume_time: got %h want 000002", disp24());
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      ifc.run_en = 1'b1;
      drive_load(23, 59, 59);
      repeat (CLK_HZ) tick_cycle();
      #2 reset = 1'b1;
      #1;
      checks++;
      if (disp24() !== 24'h000000 ||
          {ifc.tick_1hz, ifc.load_err, ifc.day_wrap, ifc.alarm_hit} !== 4'b0000) begin
         failures++; $display("FAIL reset_mid: got %h pulses=%b want 000000 0000", disp24(),
                              {ifc.tick_1hz, ifc.load_err, ifc.day_wrap, ifc.alarm_hit});
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      ifc.run_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      ifc.run_en = 1'b0; ifc.mode_12h = 1'b0; ifc.load = 1'b0;
      ifc.load_hr_t = '0; ifc.load_hr_o = '0; ifc.load_min_t = '0;
      ifc.load_min_o = '0; ifc.load_sec_t = '0; ifc.load_sec_o = '0;
      ifc.alarm_en = 1'b0; ifc.alarm_hr_t = '0; ifc.alarm_hr_o = '0;
      ifc.alarm_min_t = '0; ifc.alarm_min_o = '0;
      model_reset();
      test_reset();
      test_count();
      test_rollover();
      test_mode_12h();
      test_load_err();
      test_load_vs_tick();
      test_alarm();
      test_pause();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
